// File: rtl/axi4_lite_pkg.sv
// AXI4-Lite definitions shared by the slave register bank and the bus-master blocks.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  localparam int AXI_DATA_BYTES = 4;

  // Byte-lane merge: lanes with a strobe take the new word, the rest keep the old word.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < AXI_DATA_BYTES; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
      else         res[8*b +: 8] = old_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4_lite_wjoin.sv
// AW/W capture with held flags, join-and-commit strobe and B-channel handshake.
// The commit strobe is combinational; the response code is supplied by the register bank.
module axi4_lite_wjoin
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  input  logic [1:0]        commit_resp,
  output logic              commit,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [31:0]       commit_data,
  output logic [3:0]        commit_strb,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  logic              aw_held_r;
  logic              w_held_r;
  logic [ADDR_W-1:0] aw_addr_r;
  logic [31:0]       w_data_r;
  logic [3:0]        w_strb_r;
  logic              bvalid_r;
  logic [1:0]        bresp_r;
  logic              aw_hs_s;
  logic              w_hs_s;

  assign awready = !aw_held_r && !bvalid_r && !reset;
  assign wready  = !w_held_r && !bvalid_r && !reset;
  assign aw_hs_s = awvalid && awready;
  assign w_hs_s  = wvalid && wready;

  // A live handshake takes priority over the held copy so same-cycle AW+W commits at once.
  assign commit      = (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s) && !reset;
  assign commit_addr = aw_hs_s ? awaddr : aw_addr_r;
  assign commit_data = w_hs_s ? wdata : w_data_r;
  assign commit_strb = w_hs_s ? wstrb : w_strb_r;
  assign bvalid      = bvalid_r;
  assign bresp       = bresp_r;

  // Payload capture, held flags and write-response state.
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      aw_addr_r <= {ADDR_W{1'b0}};
      w_data_r  <= 32'd0;
      w_strb_r  <= 4'd0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      if (aw_hs_s) aw_addr_r <= awaddr;
      if (w_hs_s) begin
        w_data_r <= wdata;
        w_strb_r <= wstrb;
      end
      if (commit) begin
        aw_held_r <= 1'b0;
        w_held_r  <= 1'b0;
        bvalid_r  <= 1'b1;
        bresp_r   <= commit_resp;
      end else begin
        if (aw_hs_s) aw_held_r <= 1'b1;
        if (w_hs_s)  w_held_r  <= 1'b1;
        if (bvalid_r && bready) bvalid_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite register bank: RW slots drive REGS_OUT, RO_MASK slots read back STATUS_IN.
// Write join and B channel are in axi4_lite_wjoin; storage and the read path live here.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int                   C_AXI_DATA_WIDTH = 32,
  parameter int                   C_AXI_ADDR_WIDTH = 32,
  parameter int                   REG_COUNT        = 16,
  parameter logic [REG_COUNT-1:0] RO_MASK          = {REG_COUNT{1'b0}}
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  input  logic [2:0]                    S_AXI_ARPROT,
  output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [REG_COUNT*32-1:0]       REGS_OUT,
  input  logic [REG_COUNT*32-1:0]       STATUS_IN,
  output logic [REG_COUNT-1:0]          WR_PULSE
);

  localparam int IDX_W = $clog2(REG_COUNT);
  localparam int HI_W  = C_AXI_ADDR_WIDTH - IDX_W - 2;

  function automatic logic addr_in_range(input logic [C_AXI_ADDR_WIDTH-1:0] addr);
    return addr[C_AXI_ADDR_WIDTH-1:IDX_W+2] == {HI_W{1'b0}};
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [C_AXI_ADDR_WIDTH-1:0] addr);
    return addr[IDX_W+1:2];
  endfunction

  logic [31:0]                 regs_r [REG_COUNT];
  logic [REG_COUNT-1:0]        wr_pulse_r;
  logic                        rvalid_r;
  logic [31:0]                 rdata_r;
  logic [1:0]                  rresp_r;
  logic                        commit_s;
  logic [C_AXI_ADDR_WIDTH-1:0] commit_addr_s;
  logic [31:0]                 commit_data_s;
  logic [3:0]                  commit_strb_s;
  logic [1:0]                  commit_resp_s;
  logic [IDX_W-1:0]            widx_s;
  logic [IDX_W-1:0]            ridx_s;
  logic                        ar_hs_s;

  axi4_lite_wjoin #(.ADDR_W(C_AXI_ADDR_WIDTH)) u_wjoin (
    .clk         (S_AXI_ACLK),
    .reset       (S_AXI_ARESET),
    .awaddr      (S_AXI_AWADDR),
    .awvalid     (S_AXI_AWVALID),
    .awready     (S_AXI_AWREADY),
    .wdata       (S_AXI_WDATA),
    .wstrb       (S_AXI_WSTRB),
    .wvalid      (S_AXI_WVALID),
    .wready      (S_AXI_WREADY),
    .commit_resp (commit_resp_s),
    .commit      (commit_s),
    .commit_addr (commit_addr_s),
    .commit_data (commit_data_s),
    .commit_strb (commit_strb_s),
    .bresp       (S_AXI_BRESP),
    .bvalid      (S_AXI_BVALID),
    .bready      (S_AXI_BREADY)
  );

  assign widx_s        = addr_index(commit_addr_s);
  assign ridx_s        = addr_index(S_AXI_ARADDR);
  assign S_AXI_ARREADY = !rvalid_r && !S_AXI_ARESET;
  assign ar_hs_s       = S_AXI_ARVALID && S_AXI_ARREADY;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;
  assign WR_PULSE      = wr_pulse_r;

  // Write response code for the transaction being committed.
  always_comb begin
    commit_resp_s = RESP_OKAY;
    if (addr_in_range(commit_addr_s)) commit_resp_s = RESP_OKAY;
    else                              commit_resp_s = RESP_SLVERR;
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_out
    assign REGS_OUT[32*g +: 32] = regs_r[g];
  end

  // Register storage and one-cycle write notification; RO slots are never stored.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < REG_COUNT; i++) regs_r[i] <= 32'd0;
      wr_pulse_r <= {REG_COUNT{1'b0}};
    end else begin
      wr_pulse_r <= {REG_COUNT{1'b0}};
      if (commit_s && addr_in_range(commit_addr_s) && !RO_MASK[widx_s]) begin
        regs_r[widx_s]     <= strb_merge(regs_r[widx_s], commit_data_s, commit_strb_s);
        wr_pulse_r[widx_s] <= 1'b1;
      end
    end
  end

  // Read channel; a same-edge write is not yet visible, so the old value is returned.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'd0;
      rresp_r  <= RESP_OKAY;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      if (!addr_in_range(S_AXI_ARADDR)) begin
        rdata_r <= 32'd0;
        rresp_r <= RESP_SLVERR;
      end else if (RO_MASK[ridx_s]) begin
        rdata_r <= STATUS_IN[{ridx_s, 5'd0} +: 32];
        rresp_r <= RESP_OKAY;
      end else begin
        rdata_r <= regs_r[ridx_s];
        rresp_r <= RESP_OKAY;
      end
    end else if (rvalid_r && S_AXI_RREADY) begin
      rvalid_r <= 1'b0;
    end
  end

endmodule

// File: doc/axi4_lite_slave_regs.md
# axi4_lite_slave_regs

AXI4-Lite responder exposing a bank of REG_COUNT 32-bit control/status registers to a bus master. Sits at the slave end of the team's AXI4-Lite fabric, opposite our bus-master blocks. Write-side registers drive user logic directly; selected read-only slots report user status. Every write to a register emits a one-cycle notification strobe.

## Interface
- C_AXI_DATA_WIDTH, 32, data width; only 32 supported.
- C_AXI_ADDR_WIDTH, 32, address width.
- REG_COUNT, 16, number of registers; power of 2, 2..256.
- RO_MASK, {REG_COUNT{1'b0}}, bit i = 1 makes register i read-only (reads return STATUS_IN slice i).
- S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
- S_AXI_ARESET  in  1  reset; one clock, synchronous, active-high.
- S_AXI_AWADDR  in  C_AXI_ADDR_WIDTH  write address.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte-lane enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_AXI_ADDR_WIDTH  read address.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- REGS_OUT  out  REG_COUNT*32  flattened register contents; register i at bits [32i+31:32i].
- STATUS_IN  in  REG_COUNT*32  read values for RO_MASK slots; other slices unused.
- WR_PULSE  out  REG_COUNT  bit i high one cycle after register i is written (RW slots only).

## Operation
- Decode: index = ADDR[IDX_W+1:2], IDX_W = log2(REG_COUNT); ADDR[1:0] ignored. Address ≥ REG_COUNT*4 is out of range.
- Write path: AW and W accepted independently, either order or same cycle. AWREADY = !aw_held && !BVALID && !reset; WREADY = !w_held && !BVALID && !reset. Each handshake latches its payload and sets its held flag.
- Commit at the edge where address and data are both available (held or handshaking now): RW in-range register gets byte lanes per WSTRB; BRESP = OKAY; WR_PULSE[idx] = 1 next cycle. RO in-range: no update, no pulse, OKAY. Out of range: no update, SLVERR. Held flags clear; BVALID set.
- BVALID held, BRESP stable, until BREADY; then BVALID clears and AW/W readiness returns the next cycle.
- Read path: ARREADY = !RVALID && !reset. On AR handshake: RDATA ← register (RW), STATUS_IN slice (RO), or 0 with SLVERR (out of range); RRESP = OKAY otherwise; RVALID set. RDATA/RRESP stable until RVALID && RREADY.
- Read and write channels independent; same-edge read and write commit to one register: read returns pre-write value.
- WSTRB = 0 to RW register: no data change, WR_PULSE still fires, OKAY.

## Timing
- Reset values: all registers 0, BVALID/RVALID 0, BRESP/RRESP 00, RDATA 0, WR_PULSE 0, held flags 0, all READY 0 while reset high, AW/W/ARREADY 1 the cycle after release.
- Write: AW+W handshake edge k → REGS_OUT updated and BVALID high in cycle k+1. Peak throughput one write per 2 cycles with BREADY tied high.
- Read: AR handshake edge k → RVALID in cycle k+1; peak one read per 2 cycles.
- Reset mid-transaction: pending AW/W, BVALID, RVALID all dropped; no register write occurs on the reset edge.

## Structure
- Package axi4_lite_pkg: RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, AXI data-byte constant; shared with the bus-master blocks.
- One sub-module: axi4_lite_wjoin — AW/W capture, held flags, join-and-commit strobe, B-channel handshake. Register bank and read path stay in top level.

## Test plan
- AW+W same cycle, addr 0x08, data 0xDEADBEEF, WSTRB 0xF, BREADY=1 → BVALID next cycle, BRESP 00, REGS_OUT reg 2 = 0xDEADBEEF, WR_PULSE = 0x0004 for one cycle.
- W three cycles before AW (addr 0x04, data 0x12345678, WSTRB 0x3) on reg holding 0xFFFFFFFF → WREADY low after W accepted, reg 1 = 0xFFFF5678 only after AW handshake.
- BREADY low 5 cycles after write → BVALID/BRESP stable, AW/WREADY low throughout; second write accepted only after B handshake.
- Read addr 0x40 (REG_COUNT=16) → RRESP 10, RDATA 0; write to 0x40 → BRESP 10, no register or WR_PULSE change.
- RO_MASK bit 3, STATUS_IN slot 3 = 0xA5A5A5A5: write 0x0C → OKAY, no pulse; read 0x0C → 0xA5A5A5A5.
- AR and AW+W to reg 0 same edge (old 0, new 0x55) → RDATA 0, subsequent read 0x55; reset asserted with BVALID pending → BVALID 0, all registers 0.
